spi_controller: RTL and testbench

- SPI controller (initiator) that drives the on-chip SPI peripheral's register-write protocol: SCLK, nCS and COPI toward the peripheral, CIPO back.
- Bench and FPGA bring-up harness use it to program EN_OUT, EN_PWM_MODE and PWM_DUTY_CYCLE registers from a simple start/busy/done request interface.
- Frame is 16 bits, MSB first, SPI mode 0: R/W bit (1 = write), 7-bit address, 8-bit data.
- SCLK is derived from clk and kept slow enough for the peripheral's 2-flop input synchronisers.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_tick_gen.sv | 25 ++
 rtl/spi_controller.sv | 145 ++++++++++++++
 tb/tb_spi_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared frame geometry, peripheral register map and controller state encoding.
//   FRAME_W/ADDR_W/DATA_W : frame = {rw, addr[6:0], data[7:0]}, MSB first
//   RW_WRITE               : value of frame bit 15 for a write
//   EN_OUT_*, EN_PWM_*, PWM_DUTY_CYCLE : peripheral register addresses
//   state_e                : controller FSM states
package spi_pkg;
    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam logic RW_WRITE = 1'b1;
    localparam logic [ADDR_W-1:0] EN_OUT_7_0       = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_15_8      = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_MODE_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_MODE_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY_CYCLE   = 7'h04;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: half-period counter, one-cycle tick every DIV enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   en         : count while high
//   clr        : restart the count at zero (wins over en)
//   tick       : high in the last cycle of each DIV-cycle period
module spi_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && (cnt_q == CW'(DIV - 1));
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator issuing 16-bit {rw, addr, data} frames.
//   clk, rst_n        : clock, async active-low reset
//   start             : request, sampled only in IDLE
//   rw, addr, wdata   : frame contents, latched when start is accepted
//   cipo              : serial data from the peripheral
//   busy              : frame in progress (through the inter-frame gap)
//   done              : one-cycle pulse at end of frame
//   rdata             : byte captured from cipo during the data phase
//   sclk, ncs, copi   : SPI bus toward the peripheral (all registered)
module spi_controller import spi_pkg::*; #(
    parameter int CLK_DIV_HALF = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cipo,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              ncs,
    output logic              copi
);
    if (CLK_DIV_HALF < 3) begin : g_bad_div
        $error("CLK_DIV_HALF must be 3 or more");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be 1 or more");
    end
    localparam int GW = $clog2(GAP_CYCLES + 1);
    state_e state_q, state_d;
    // rw goes straight to copi on acceptance, so only addr/data need holding
    logic [FRAME_W-2:0] frame_q, frame_d;
    logic [3:0]         bit_q, bit_d;
    logic               low_q, low_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d, rdata_q, rdata_d;
    logic sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d, busy_q, busy_d, done_q, done_d;
    logic tick;
    spi_tick_gen #(.DIV(CLK_DIV_HALF)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD}),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        low_d    = low_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        sclk_d   = sclk_q;
        ncs_d    = ncs_q;
        copi_d   = copi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                frame_d = {addr, wdata};
                copi_d  = rw;
                ncs_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_SETUP;
            end
            ST_SETUP: if (tick) begin
                sclk_d  = 1'b1;
                bit_d   = '0;
                low_d   = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (tick) begin
                if (!low_q) begin
                    // falling edge: present the next bit; the last bit is simply held
                    sclk_d = 1'b0;
                    low_d  = 1'b1;
                    if (bit_q != 4'd15) copi_d = frame_q[4'd14 - bit_q];
                end else if (bit_q == 4'd15) begin
                    state_d = ST_HOLD;
                end else begin
                    // rising edge of bit bit_q+1; bits 8..15 carry peripheral data
                    sclk_d = 1'b1;
                    low_d  = 1'b0;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q >= 4'd7) shadow_d = {shadow_q[DATA_W-2:0], cipo};
                end
            end
            ST_HOLD: if (tick) begin
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
                done_d  = 1'b1;
                rdata_d = shadow_q;
                gap_d   = GW'(GAP_CYCLES - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                gap_d   = (gap_q == '0) ? gap_q : gap_q - 1'b1;
                busy_d  = (gap_q != '0);
                state_d = (gap_q == '0) ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            bit_q    <= '0;
            low_q    <= 1'b0;
            gap_q    <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            copi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            bit_q    <= bit_d;
            low_q    <= low_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            sclk_q   <= sclk_d;
            ncs_q    <= ncs_d;
            copi_q   <= copi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign ncs   = ncs_q;
    assign copi  = copi_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed vector bench for spi_controller with a behavioural peripheral.
module tb_spi_controller;
    localparam int DIVH = 4;
    localparam int GAP  = 4;
    logic clk = 1'b0;
    logic rst_n, start, rw, cipo;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic busy, done, sclk, ncs, copi;
    int n_chk = 0;
    int n_err = 0;
    spi_controller #(.CLK_DIV_HALF(DIVH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .cipo(cipo), .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .ncs(ncs), .copi(copi)
    );
    always #5 clk = ~clk;
    // behavioural peripheral: shifts copi on sclk rise, commits complete write frames when ncs rises
    logic [7:0]  regs [0:127];
    logic [15:0] p_sh = '0;
    int          p_bits = 0;
    always @(posedge sclk or posedge ncs) begin
        if (ncs) begin
            if (p_bits == 16 && p_sh[15]) regs[p_sh[14:8]] <= p_sh[7:0];
            p_bits <= 0;
        end else begin
            p_sh   <= {p_sh[14:0], copi};
            p_bits <= p_bits + 1;
        end
    end
    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] cipo_b;
        bit         hammer;
        logic [15:0] exp_word;
        logic [7:0]  exp_rdata;
    } vec_t;
    vec_t vecs [7];
    logic [15:0] m_word;
    logic [7:0]  m_rdata;
    int m_rises, m_ncs_low, m_done, m_gap, m_overlap, m_idle_low;
    bit m_timeout;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                             input logic [7:0] cb, input bit hammer);
        logic ps, pn, pb;
        int falls, ncs_rise;
        @(negedge clk);
        rw = r; addr = a; wdata = d; cipo = 1'b0; start = 1'b1;
        @(negedge clk);
        start = hammer; rw = ~r; addr = ~a; wdata = ~d;
        m_word = '0; m_rdata = '0; m_rises = 0; m_ncs_low = 0; m_done = 0;
        m_gap = -1; m_overlap = 0; m_idle_low = 0; m_timeout = 1'b1;
        ps = 1'b0; pn = 1'b0; pb = 1'b1; falls = 0; ncs_rise = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (sclk && !ps) begin
                m_word = {m_word[14:0], copi};
                m_rises++;
            end
            if (!sclk && ps) begin
                falls++;
                if (falls >= 8 && falls <= 15) cipo = cb[15 - falls];
            end
            if (!ncs) m_ncs_low++;
            if (sclk && ncs) m_overlap++;
            if (done) begin
                m_done++;
                m_rdata = rdata;
            end
            if (ncs && !pn) ncs_rise = cyc;
            if (!busy && pb) begin
                m_gap = cyc - ncs_rise;
                m_timeout = 1'b0;
                break;
            end
            if (hammer) wdata = wdata + 8'd1;
            ps = sclk; pn = ncs; pb = busy;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!ncs) m_idle_low++;
            if (done) m_done++;
        end
    endtask
    initial begin
        int rises, lows, ndone, hi;
        bit got, seen_low;
        logic ps, pn;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        vecs[0] = '{1'b1, 7'h04, 8'h80, 8'h00, 1'b0, 16'h8480, 8'h00};
        vecs[1] = '{1'b1, 7'h00, 8'hF0, 8'h3C, 1'b0, 16'h80F0, 8'h3C};
        vecs[2] = '{1'b1, 7'h02, 8'h0F, 8'h00, 1'b0, 16'h820F, 8'h00};
        vecs[3] = '{1'b0, 7'h01, 8'h00, 8'hA5, 1'b0, 16'h0100, 8'hA5};
        vecs[4] = '{1'b1, 7'h55, 8'hAA, 8'h00, 1'b1, 16'hD5AA, 8'h00};
        vecs[5] = '{1'b0, 7'h7F, 8'hFF, 8'hFF, 1'b0, 16'h7FFF, 8'hFF};
        vecs[6] = '{1'b1, 7'h04, 8'h40, 8'h5A, 1'b0, 16'h8440, 8'h5A};
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; cipo = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ncs", 32'(ncs), 1);
        chk("reset_sclk", 32'(sclk), 0);
        chk("reset_copi", 32'(copi), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_rdata", 32'(rdata), 0);
        rst_n = 1'b1;
        // abort: reset asserted at the 7th sclk rising edge
        @(negedge clk);
        rw = 1'b1; addr = 7'h03; wdata = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0; ps = 1'b0; got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (sclk && !ps) rises++;
            ps = sclk;
            if (rises == 7) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reach7", 32'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ncs", 32'(ncs), 1);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_copi", 32'(copi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rdata", 32'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) ndone++;
            if (!ncs) lows++;
        end
        chk("abort_no_done", 32'(ndone), 0);
        chk("abort_stays_idle", 32'(lows), 0);
        chk("abort_rdata_after", 32'(rdata), 0);
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].cipo_b, vecs[i].hammer);
            chk($sformatf("v%0d_timeout", i), 32'(m_timeout), 0);
            chk($sformatf("v%0d_copi_word", i), 32'(m_word), 32'(vecs[i].exp_word));
            chk($sformatf("v%0d_rises", i), 32'(m_rises), 16);
            chk($sformatf("v%0d_ncs_low", i), 32'(m_ncs_low), 34 * DIVH);
            chk($sformatf("v%0d_done_pulses", i), 32'(m_done), 1);
            chk($sformatf("v%0d_rdata", i), 32'(m_rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_busy_gap", i), 32'(m_gap), GAP);
            chk($sformatf("v%0d_sclk_ncs_high", i), 32'(m_overlap), 0);
            chk($sformatf("v%0d_no_extra_frame", i), 32'(m_idle_low), 0);
            chk($sformatf("v%0d_rdata_held", i), 32'(rdata), 32'(vecs[i].exp_rdata));
        end
        chk("loop_en_out_7_0", 32'(regs[0]), 32'h F0);
        chk("loop_en_pwm_mode_7_0", 32'(regs[2]), 32'h0F);
        chk("loop_pwm_duty", 32'(regs[4]), 32'h40);
        chk("loop_read_ignored", 32'(regs[1]), 0);
        chk("loop_aborted_ignored", 32'(regs[3]), 0);
        chk("loop_hammer_write", 32'(regs[7'h55]), 32'hAA);
        // start held high: measure ncs-high span between two consecutive frames
        @(negedge clk);
        rw = 1'b1; addr = 7'h10; wdata = 8'h11; start = 1'b1;
        seen_low = 1'b0; hi = 0; got = 1'b0; pn = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!ncs && !pn && hi > 0) begin
                got = 1'b1;
                break;
            end
            if (!ncs) seen_low = 1'b1;
            if (ncs && seen_low) hi++;
            pn = ncs;
        end
        start = 1'b0;
        chk("held_second_frame", 32'(got), 1);
        chk("held_gap_min", 32'(hi >= GAP), 1);
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("held_returns_idle", 32'(got), 1);
        chk("held_write", 32'(regs[7'h10]), 32'h11);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
